relay_framer: RTL

Parametrised frame detector for the 13.56 MHz relay path. It samples a serial relay bit stream at a divided rate and shifts it through a delay buffer. It detects reader and tag start/end-of-frame patterns, switches the hi_iso14443a modulation type between listen and modulate, and aborts frames that run too long. It sits between the relay input and hi_iso14443a, replacing the fixed-pattern logic in the top level.

---
 rtl/relay_framer_if.sv | 22 ++
 rtl/relay_framer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/relay_framer_if.sv
// Signal bundle between the relay bit source, relay_framer and hi_iso14443a.
// The relay source drives mode/bit_in; the framer returns modulation and frame status.
interface relay_framer_if;
  logic [2:0] mode;
  logic       bit_in;
  logic [2:0] mod_type;
  logic       data_out;
  logic       bit_strobe;
  logic       frame_active;
  logic       frame_done;
  logic       frame_err;

  modport master (
    output mode, bit_in,
    input  mod_type, data_out, bit_strobe, frame_active, frame_done, frame_err
  );

  modport slave (
    input  mode, bit_in,
    output mod_type, data_out, bit_strobe, frame_active, frame_done, frame_err
  );
endinterface

// File: rtl/relay_framer.sv
// Relay-path frame detector: divided-rate sampling into a delay line, start/end-of-frame
// matching for fake-reader / fake-tag relay, and timeout abort of over-long frames.
//   state     | meaning
//   ST_IDLE   | waiting for a start-of-frame pattern (listen modulation)
//   ST_ACTIVE | inside a frame, counting samples (modulate)
module relay_framer #(
  parameter int unsigned DIV_W          = 4,
  parameter int unsigned BUF_W          = 24,
  parameter int unsigned TAP            = 7,
  parameter logic [7:0]  READER_START   = 8'hc0,
  parameter logic [15:0] READER_END_1   = 16'h0000,
  parameter logic [15:0] READER_END_2   = 16'hc000,
  parameter logic [7:0]  TAG_START      = 8'hf0,
  parameter logic [7:0]  TAG_END        = 8'h00,
  parameter int unsigned MAX_FRAME_BITS = 4096
) (
  input logic           ck_1356meg,
  input logic           nreset,
  relay_framer_if.slave bus
);

  localparam logic [2:0]       MODE_FAKE_READER = 3'd5;
  localparam logic [2:0]       MODE_FAKE_TAG    = 3'd6;
  localparam logic [DIV_W-1:0] STROBE_AT        = DIV_W'(2 ** (DIV_W - 1));
  localparam logic [15:0]      MAX_FB           = 16'(MAX_FRAME_BITS);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t             r_state, w_state_nxt;
  logic [DIV_W-1:0]   r_div_cnt;
  logic               r_bit_strobe;
  logic [2:0]         r_mode_q;
  logic [BUF_W-1:0]   r_buf, w_buf_nxt;
  logic [2:0]         r_bit_cnt, w_bit_cnt_nxt;
  logic [15:0]        r_frame_bits, w_frame_bits_nxt;
  logic               r_done, w_done_nxt;
  logic               r_err, w_err_nxt;

  logic               w_strobe;
  logic               w_relay;
  logic               w_mode_chg;
  logic [BUF_W-1:0]   w_buf_shift;
  logic [2:0]         w_bit_cnt_inc;
  logic [15:0]        w_frame_bits_inc;
  logic [7:0]         w_start_byte;
  logic               w_start_hit;
  logic               w_end_hit;

  assign w_strobe         = (r_div_cnt == STROBE_AT);
  assign w_relay          = (bus.mode == MODE_FAKE_READER) || (bus.mode == MODE_FAKE_TAG);
  assign w_mode_chg       = (bus.mode != r_mode_q);
  assign w_buf_shift      = {r_buf[BUF_W-2:0], bus.bit_in};
  assign w_bit_cnt_inc    = r_bit_cnt + 3'd1;
  assign w_frame_bits_inc = (r_frame_bits == 16'hffff) ? r_frame_bits : r_frame_bits + 16'd1;
  assign w_start_byte     = (bus.mode == MODE_FAKE_READER) ? READER_START : TAG_START;
  assign w_start_hit      = (w_buf_shift[23:0] == {16'h0000, w_start_byte});
  assign w_end_hit        = (bus.mode == MODE_FAKE_READER) ?
                            ((w_buf_shift[23:8] == READER_END_1) || (w_buf_shift[23:8] == READER_END_2)) :
                            (w_buf_shift[15:8] == TAG_END);

  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      r_div_cnt    <= '0;
      r_bit_strobe <= 1'b0;
      r_mode_q     <= 3'd0;
      r_state      <= ST_IDLE;
      r_buf        <= '0;
      r_bit_cnt    <= 3'd0;
      r_frame_bits <= 16'd0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_div_cnt    <= r_div_cnt + DIV_W'(1);
      r_bit_strobe <= w_strobe;
      r_mode_q     <= bus.mode;
      r_state      <= w_state_nxt;
      r_buf        <= w_buf_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_frame_bits <= w_frame_bits_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_buf_nxt        = r_buf;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_frame_bits_nxt = r_frame_bits;
    w_done_nxt       = 1'b0;
    w_err_nxt        = 1'b0;
    // A mode change overrides any coincident strobe: restart silently.
    if (!w_relay || w_mode_chg) begin
      w_state_nxt      = ST_IDLE;
      w_buf_nxt        = '0;
      w_bit_cnt_nxt    = 3'd0;
      w_frame_bits_nxt = 16'd0;
    end else if (w_strobe) begin
      w_buf_nxt = w_buf_shift;
      case (r_state)
        ST_IDLE: begin
          if (w_start_hit) begin
            w_state_nxt      = ST_ACTIVE;
            w_bit_cnt_nxt    = 3'd0;
            w_frame_bits_nxt = 16'd0;
          end
        end
        ST_ACTIVE: begin
          w_bit_cnt_nxt    = w_bit_cnt_inc;
          w_frame_bits_nxt = w_frame_bits_inc;
          if ((w_bit_cnt_inc == 3'd0) && w_end_hit) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else if (w_frame_bits_inc == MAX_FB) begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
            w_buf_nxt   = '0;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mod_type = bus.mode;
    if (bus.mode == MODE_FAKE_READER)
      bus.mod_type = (r_state == ST_ACTIVE) ? 3'd2 : 3'd1;
    else if (bus.mode == MODE_FAKE_TAG)
      bus.mod_type = (r_state == ST_ACTIVE) ? 3'd4 : 3'd3;
  end

  assign bus.data_out     = r_buf[TAP];
  assign bus.bit_strobe   = r_bit_strobe;
  assign bus.frame_active = (r_state == ST_ACTIVE);
  assign bus.frame_done   = r_done;
  assign bus.frame_err    = r_err;

endmodule
